// File: rtl/ddr_ecc_pkg.sv
// Shared types and codeword layout for the DDR read-path (72,64) extended-Hamming checker.
package ddr_ecc_pkg;

  localparam int DATA_W     = 64;
  localparam int ECC_W      = 8;
  localparam int CW_POS     = 71;
  localparam int SYN_W      = 7;
  // Widest beat address an error record can carry; top-level ADDR_W must not exceed it.
  localparam int REC_ADDR_W = 28;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_CE   = 2'b01,
    ERR_UE   = 2'b10
  } err_type_t;

  typedef struct packed {
    logic [REC_ADDR_W-1:0] addr;
    logic [ECC_W-1:0]      syndrome;
    err_type_t             etype;
  } err_rec_t;

  // Data bit idx occupies the idx-th non-power-of-two codeword position (data[0] -> 3).
  function automatic int data_pos(input int idx);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int pos = 1; pos <= CW_POS; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (cnt == idx) res = pos;
        cnt++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ecc_secded_syndrome.sv
// Combinational SECDED syndrome: s = XOR of set-bit positions 1..71, p = parity of all 72 bits.
module ecc_secded_syndrome
  import ddr_ecc_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [ECC_W-1:0]  ecc_i,
  output logic [SYN_W-1:0]  syn_o,
  output logic              par_o
);

  logic [SYN_W-1:0] term [DATA_W];

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_term
    localparam logic [SYN_W-1:0] POS = SYN_W'(data_pos(gi));
    assign term[gi] = data_i[gi] ? POS : '0;
  end

  // Check bit k sits at position 2^k, so it contributes exactly syndrome bit k.
  always_comb begin
    syn_o = ecc_i[SYN_W-1:0];
    for (int i = 0; i < DATA_W; i++) begin
      syn_o = syn_o ^ term[i];
    end
  end

  assign par_o = ^{data_i, ecc_i};

endmodule

// File: rtl/ecc_read_checker.sv
// Two-stage SECDED read checker: corrects data in-line and hands error records to error_buffer.
module ecc_read_checker
  import ddr_ecc_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [ECC_W-1:0]  rd_ecc,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_uncorr,
  output logic              err_valid,
  input  logic              err_ready,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ECC_W-1:0]  err_syndrome,
  output logic [1:0]        err_type,
  output logic [CNT_W-1:0]  drop_count
);

  localparam logic [SYN_W-1:0] MAX_POS = SYN_W'(CW_POS);

  logic [SYN_W-1:0]  syn_c;
  logic              par_c;

  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [SYN_W-1:0]  s1_syn_q;
  logic              s1_par_q;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_uncorr_q;
  err_rec_t          slot_q, slot_d, rec_c;
  logic              err_valid_q, err_valid_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic [DATA_W-1:0] flip_mask;
  logic              is_ce, is_ue, new_err, accept, load_slot;

  ecc_secded_syndrome u_syndrome (
    .data_i (rd_data),
    .ecc_i  (rd_ecc),
    .syn_o  (syn_c),
    .par_o  (par_c)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_addr_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else begin
      s1_valid_q <= rd_valid;
      s1_data_q  <= rd_data;
      s1_addr_q  <= rd_addr;
      s1_syn_q   <= syn_c;
      s1_par_q   <= par_c;
    end
  end

  // A syndrome pointing at a check-bit position matches no data bit, leaving data untouched.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_fix
    localparam logic [SYN_W-1:0] POS = SYN_W'(data_pos(gi));
    assign flip_mask[gi] = (s1_syn_q == POS);
  end

  assign is_ce     = s1_valid_q & s1_par_q & (s1_syn_q <= MAX_POS);
  assign is_ue     = s1_valid_q & (s1_par_q ? (s1_syn_q > MAX_POS) : (s1_syn_q != '0));
  assign new_err   = is_ce | is_ue;
  assign accept    = err_valid_q & err_ready;
  assign load_slot = new_err & (~err_valid_q | accept);

  always_comb begin
    rec_c          = '0;
    rec_c.addr     = REC_ADDR_W'(s1_addr_q);
    rec_c.syndrome = {s1_par_q, s1_syn_q};
    rec_c.etype    = is_ue ? ERR_UE : ERR_CE;

    slot_d      = load_slot ? rec_c : slot_q;
    err_valid_d = load_slot | (err_valid_q & ~accept);

    drop_d = drop_q;
    if (new_err && err_valid_q && !accept && (drop_q != '1)) begin
      drop_d = drop_q + CNT_W'(1);
    end

    out_data_d = is_ce ? (s1_data_q ^ flip_mask) : s1_data_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_uncorr_q <= 1'b0;
      slot_q       <= '0;
      err_valid_q  <= 1'b0;
      drop_q       <= '0;
    end else begin
      out_valid_q  <= s1_valid_q;
      out_data_q   <= out_data_d;
      out_uncorr_q <= is_ue;
      slot_q       <= slot_d;
      err_valid_q  <= err_valid_d;
      drop_q       <= drop_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_uncorr   = out_uncorr_q;
  assign err_valid    = err_valid_q;
  assign err_addr     = ADDR_W'(slot_q.addr);
  assign err_syndrome = slot_q.syndrome;
  assign err_type     = slot_q.etype;
  assign drop_count   = drop_q;

endmodule
